mcpu_imem_loader: RTL and testbench

//  Instruction-memory stage upstream of the MCPU core: owns the byte-wide instruction RAM,

---
 rtl/mcpu_imem_loader_pkg.sv | 15 +
 rtl/mcpu_imem_loader_if.sv | 10 +
 rtl/mcpu_imem_loader_ram.sv | 23 ++
 rtl/mcpu_imem_loader.sv | 92 +++++++++
 tb/tb_mcpu_imem_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_imem_loader_pkg.sv
// Shared definitions for the MCPU instruction-memory loader: FSM state encodings
// and the halt opcode fed to the core when the PC is outside the loaded program.
package mcpu_imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } imem_state_e;

  // MOV PC<-PC: the core spins in place on this opcode.
  localparam logic [7:0] MCPU_HALT_OPCODE = 8'h00;

endpackage

// File: rtl/mcpu_imem_loader_if.sv
// Byte-stream program load channel (valid/ready with last-byte marker).
interface mcpu_imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/mcpu_imem_loader_ram.sv
// Byte-wide instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module mcpu_imem_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [7:0]            rdata
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mcpu_imem_loader.sv
// Instruction-memory stage for the MCPU core: loads a program from a byte stream,
// holds the core in reset while loading and serves irom_in from cnt_pc in RUN.
// Optional MCPU_IMEM_CHECKSUM_EN adds load_sum, the mod-256 sum of accepted bytes.
module mcpu_imem_loader
  import mcpu_imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  mcpu_imem_loader_if.slave     strm,
  input  logic [DATA_WIDTH-1:0] cnt_pc,
  output logic [7:0]            irom_in,
  output logic                  core_reset,
  output logic                  loading,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  err_ovf
`ifdef MCPU_IMEM_CHECKSUM_EN
  ,
  output logic [7:0]            load_sum
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  imem_state_e           state, state_n;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  full, acc;
  logic [7:0]            rdata;

  assign full          = (wptr == DEPTH);
  assign strm.in_ready = (state == ST_LOAD) & ~load_start & ~full;
  assign acc           = strm.in_valid & strm.in_ready;

  always_comb begin
    state_n = state;
    if (load_start) begin
      state_n = ST_LOAD;
    end else if (state == ST_LOAD) begin
      if (acc && strm.in_last) state_n = ST_RUN;
      else if (full)           state_n = ST_ERR;
    end
  end

  // wptr doubles as load_count: both restart together and advance on every accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      err_ovf    <= 1'b0;
      wptr       <= '0;
    end else begin
      state      <= state_n;
      core_reset <= (state_n != ST_RUN);
      load_done  <= (state == ST_LOAD) && (state_n == ST_RUN);
      err_ovf    <= ~load_start & (err_ovf | ((state == ST_LOAD) && (state_n == ST_ERR)));
      if (load_start) wptr <= '0;
      else if (acc)   wptr <= wptr + 1'b1;
    end
  end

`ifdef MCPU_IMEM_CHECKSUM_EN
  logic [7:0] sum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           sum_q <= '0;
    else if (load_start) sum_q <= '0;
    else if (acc)        sum_q <= sum_q + strm.in_data;
  end
  assign load_sum = sum_q;
`endif

  mcpu_imem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (acc),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (strm.in_data),
    .raddr (cnt_pc[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  assign loading    = (state == ST_LOAD);
  assign load_count = wptr;

  // Full-width compare so a PC beyond the program never aliases onto low RAM.
  assign irom_in = ((state == ST_RUN) && (cnt_pc < DATA_WIDTH'(wptr))) ? rdata
                                                                       : MCPU_HALT_OPCODE;

endmodule

// File: tb/tb_mcpu_imem_loader.sv
// Bench for mcpu_imem_loader: two instances (256-byte and 16-byte RAM) share one
// stimulus stream and are checked against a behavioural model, a vector table and
// directed overflow / restart / async-reset sequences.
module tb_mcpu_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [31:0] cnt_pc = 32'h0;

  always #5 clk = ~clk;

  mcpu_imem_loader_if if8();
  mcpu_imem_loader_if if4();
  assign if8.in_valid = in_valid;
  assign if8.in_data  = in_data;
  assign if8.in_last  = in_last;
  assign if4.in_valid = in_valid;
  assign if4.in_data  = in_data;
  assign if4.in_last  = in_last;

  logic [7:0] irom8, irom4;
  logic       cr8, cr4, ld8, ld4, dn8, dn4, eo8, eo4;
  logic [8:0] cnt8;
  logic [4:0] cnt4;
`ifdef MCPU_IMEM_CHECKSUM_EN
  logic [7:0] sum8, sum4;
`endif

  mcpu_imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load_start(load_start), .strm(if8), .cnt_pc(cnt_pc),
    .irom_in(irom8), .core_reset(cr8), .loading(ld8), .load_done(dn8),
    .load_count(cnt8), .err_ovf(eo8)
`ifdef MCPU_IMEM_CHECKSUM_EN
    , .load_sum(sum8)
`endif
  );

  mcpu_imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .load_start(load_start), .strm(if4), .cnt_pc(cnt_pc),
    .irom_in(irom4), .core_reset(cr4), .loading(ld4), .load_done(dn4),
    .load_count(cnt4), .err_ovf(eo4)
`ifdef MCPU_IMEM_CHECKSUM_EN
    , .load_sum(sum4)
`endif
  );

  // ---------------- reference model (index 0: 256 bytes, 1: 16 bytes)
  int         m_wptr [2];
  bit         m_load [2], m_run [2], m_err [2], m_done [2];
  logic [7:0] m_sum  [2];
  logic [7:0] m_mem  [2][256];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int depth(int k);
    return (k == 0) ? 256 : 16;
  endfunction

  function automatic logic [7:0] m_irom(int k);
    if (m_run[k] && (longint'(cnt_pc) < longint'(m_wptr[k]))) return m_mem[k][cnt_pc[7:0]];
    return 8'h00;
  endfunction

  function automatic bit m_ready(int k);
    return m_load[k] && !load_start && (m_wptr[k] != depth(k));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wptr[k] = 0; m_load[k] = 0; m_run[k] = 0; m_err[k] = 0; m_done[k] = 0; m_sum[k] = 8'h00;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (load_start) begin
        m_load[k] = 1; m_run[k] = 0; m_err[k] = 0; m_wptr[k] = 0; m_sum[k] = 8'h00;
      end else if (m_load[k]) begin
        if (m_wptr[k] == depth(k)) begin
          m_load[k] = 0; m_err[k] = 1;
        end else if (in_valid) begin
          m_mem[k][m_wptr[k]] = in_data;
          m_wptr[k] = m_wptr[k] + 1;
          m_sum[k] = m_sum[k] + in_data;
          if (in_last) begin
            m_load[k] = 0; m_run[k] = 1; m_done[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_dut(int k, logic [7:0] irom, logic rdy, logic cr, logic ld, logic dn,
                         logic [8:0] cnt, logic eo, logic [7:0] sum);
    chk($sformatf("irom[%0d]", k),       32'(irom), 32'(m_irom(k)));
    chk($sformatf("in_ready[%0d]", k),   32'(rdy),  32'(m_ready(k)));
    chk($sformatf("core_reset[%0d]", k), 32'(cr),   32'(!m_run[k]));
    chk($sformatf("loading[%0d]", k),    32'(ld),   32'(m_load[k]));
    chk($sformatf("load_done[%0d]", k),  32'(dn),   32'(m_done[k]));
    chk($sformatf("load_count[%0d]", k), 32'(cnt),  32'(m_wptr[k]));
    chk($sformatf("err_ovf[%0d]", k),    32'(eo),   32'(m_err[k]));
`ifdef MCPU_IMEM_CHECKSUM_EN
    chk($sformatf("load_sum[%0d]", k),   32'(sum),  32'(m_sum[k]));
`else
    if (sum != 8'h00) $display("note: unexpected sum argument");
`endif
  endtask

  task automatic check_all();
`ifdef MCPU_IMEM_CHECKSUM_EN
    chk_dut(0, irom8, if8.in_ready, cr8, ld8, dn8, cnt8, eo8, sum8);
    chk_dut(1, irom4, if4.in_ready, cr4, ld4, dn4, {4'b0, cnt4}, eo4, sum4);
`else
    chk_dut(0, irom8, if8.in_ready, cr8, ld8, dn8, cnt8, eo8, 8'h00);
    chk_dut(1, irom4, if4.in_ready, cr4, ld4, dn4, {4'b0, cnt4}, eo4, 8'h00);
`endif
  endtask

  // Entered just after a falling edge; leaves on the next falling edge.
  task automatic step(logic ls, logic v, logic [7:0] d, logic last, logic [31:0] pc);
    load_start = ls; in_valid = v; in_data = d; in_last = last; cnt_pc = pc;
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- vector table for the basic 4-byte load and readback
  typedef struct {
    logic ls, v, last; logic [7:0] d; logic [31:0] pc;
    logic e_rdy, e_cr, e_dn; logic [8:0] e_cnt; logic [7:0] e_irom;
  } vec_t;

  function automatic vec_t mk(int ls, int v, int last, int d, int pc,
                              int rdy, int cr, int dn, int cnt, int irom);
    vec_t r;
    r.ls = ls[0]; r.v = v[0]; r.last = last[0]; r.d = d[7:0]; r.pc = 32'(pc);
    r.e_rdy = rdy[0]; r.e_cr = cr[0]; r.e_dn = dn[0]; r.e_cnt = cnt[8:0]; r.e_irom = irom[7:0];
    return r;
  endfunction

  vec_t tbl [12];

  initial begin
    tbl[0]  = mk(1, 0, 0, 'h00, 'h0,        0, 1, 0, 0, 'h00);
    tbl[1]  = mk(0, 1, 0, 'h83, 'h0,        1, 1, 0, 0, 'h00);
    tbl[2]  = mk(0, 1, 0, 'h0B, 'h0,        1, 1, 0, 1, 'h00);
    tbl[3]  = mk(0, 1, 0, 'h85, 'h0,        1, 1, 0, 2, 'h00);
    tbl[4]  = mk(0, 1, 1, 'h40, 'h0,        1, 1, 0, 3, 'h00);
    tbl[5]  = mk(0, 0, 0, 'h00, 'h0,        0, 0, 1, 4, 'h83);
    tbl[6]  = mk(0, 0, 0, 'h00, 'h1,        0, 0, 0, 4, 'h0B);
    tbl[7]  = mk(0, 0, 0, 'h00, 'h2,        0, 0, 0, 4, 'h85);
    tbl[8]  = mk(0, 0, 0, 'h00, 'h3,        0, 0, 0, 4, 'h40);
    tbl[9]  = mk(0, 0, 0, 'h00, 'h4,        0, 0, 0, 4, 'h00);
    tbl[10] = mk(0, 1, 0, 'h77, 'h100,      0, 0, 0, 4, 'h00);
    tbl[11] = mk(0, 0, 0, 'h00, 'hFFFFFFFF, 0, 0, 0, 4, 'h00);

    // reset state
    model_reset();
    #1 reset = 1'b1;
    #2 check_all();
    chk("rst core_reset", 32'(cr8), 32'd1);
    chk("rst load_count", 32'(cnt8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 8'h00, 0, 32'h0);

    // basic load + readback, out-of-range PCs
    for (int i = 0; i < 12; i++) begin
      load_start = tbl[i].ls; in_valid = tbl[i].v; in_data = tbl[i].d;
      in_last = tbl[i].last; cnt_pc = tbl[i].pc;
      #1;
      chk($sformatf("tbl%0d rdy8", i),  32'(if8.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d cr8", i),   32'(cr8),          32'(tbl[i].e_cr));
      chk($sformatf("tbl%0d dn8", i),   32'(dn8),          32'(tbl[i].e_dn));
      chk($sformatf("tbl%0d cnt8", i),  32'(cnt8),         32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d irom8", i), 32'(irom8),        32'(tbl[i].e_irom));
      chk($sformatf("tbl%0d irom4", i), 32'(irom4),        32'(tbl[i].e_irom));
      step(tbl[i].ls, tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].pc);
    end

    // 16-byte RAM overflow without in_last, then clear via load_start
    step(1, 0, 8'h00, 0, 32'h0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), 0, 32'h0);
    load_start = 0; in_valid = 1;
    #1 chk("ovf in_ready4", 32'(if4.in_ready), 32'd0);
    chk("ovf count4", 32'(cnt4), 32'd16);
    step(0, 1, 8'h5A, 0, 32'h0);
    #1 chk("ovf err4", 32'(eo4), 32'd1);
    chk("ovf core_reset4", 32'(cr4), 32'd1);
    chk("ovf loading4", 32'(ld4), 32'd0);
    step(0, 1, 8'h11, 1, 32'h0);
    step(0, 0, 8'h00, 0, 32'h0);
    step(1, 0, 8'h00, 0, 32'h0);
    #1 chk("ovf cleared4", 32'(eo4), 32'd0);

    // 16 bytes with in_last on the final byte: legal full load
    for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), (i == 15) ? 1'b1 : 1'b0, 32'h0);
    #1 chk("full count4", 32'(cnt4), 32'd16);
    chk("full err4", 32'(eo4), 32'd0);
    chk("full core_reset4", 32'(cr4), 32'd0);
    for (int p = 0; p < 18; p++) step(0, 0, 8'h00, 0, 32'(p));

    // restart mid-load with a byte offered in the same cycle
    step(1, 0, 8'h00, 0, 32'h0);
    step(0, 1, 8'hA1, 0, 32'h0);
    step(0, 1, 8'hA2, 0, 32'h0);
    step(1, 1, 8'hEE, 0, 32'h0);
    #1 chk("restart count8", 32'(cnt8), 32'd0);
    step(0, 1, 8'hC1, 0, 32'h0);
    step(0, 1, 8'hC2, 0, 32'h0);
    step(0, 1, 8'hC3, 1, 32'h0);
    #1 chk("restart count3", 32'(cnt8), 32'd3);
    for (int p = 0; p < 4; p++) step(0, 0, 8'h00, 0, 32'(p));

    // async reset between edges during a load; checksum of {FF,02}
    step(1, 0, 8'h00, 0, 32'h0);
    step(0, 1, 8'hFF, 0, 32'h0);
    step(0, 1, 8'h02, 0, 32'h0);
    in_valid = 0;
`ifdef MCPU_IMEM_CHECKSUM_EN
    #1 chk("sum FF+02", 32'(sum8), 32'h01);
`endif
    #2 reset = 1'b1;
    model_reset();
    #1 chk("arst core_reset", 32'(cr8), 32'd1);
    chk("arst loading", 32'(ld8), 32'd0);
    chk("arst count", 32'(cnt8), 32'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           8'($urandom),
           ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
